bcd_counter: RTL and testbench
==============================

# bcd_counter

Four-digit synchronous BCD up/down counter with a built-in prescaler, producing one decimal digit per output for the per-digit 7-segment decoders downstream. Each digit output is 7 bits wide, carries a value 0–9 and drives one decoder input directly. The block sits between the board clock and the display decode stage, and forms the counting core of the counter design.

## Interface
- TICK_DIV, 50_000_000: enabled clock cycles per count step; legal range ≥ 1. Prescaler width is $clog2(TICK_DIV), minimum 1 bit.
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  count enable; low freezes the prescaler and the count
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on step cycles only
- clr  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous load of load_val
- load_val  in  16  four BCD nibbles: [3:0] = digit0 (units) … [15:12] = digit3 (thousands)
- digit0  out  7  units digit, 0–9, bits [6:4] always 0
- digit1  out  7  tens digit, same format
- digit2  out  7  hundreds digit, same format
- digit3  out  7  thousands digit, same format
- step  out  1  high in any cycle where a count step is taken (en=1 and prescaler = TICK_DIV-1, with no clr or load)
- wrap  out  1  registered one-cycle pulse, high in the cycle after a step that wrapped 9999→0000 (up) or 0000→9999 (down)

## Operation
- Priority at each rising edge: rst_n=0 > clr > load > step > hold.
- Reset (rst_n=0): all digits, the prescaler and wrap go to 0.
- clr=1: all digits and the prescaler go to 0. wrap goes to 0. en is ignored.
- load=1: each digit takes its nibble from load_val. A nibble greater than 9 loads as 0, per digit independently. The prescaler goes to 0 and wrap goes to 0.
- Prescaler:
  - With en=1, it counts 0…TICK_DIV-1 and then returns to 0.
  - With en=0, it holds.
  - With TICK_DIV=1, it is constantly 0, so a step occurs in every enabled cycle.
- Step, up=1:
  - digit0 increments. On 9 it goes to 0 and carries into digit1, and so on up the chain.
  - The carry out of digit3 wraps the count to 0000 and sets wrap the next cycle.
- Step, up=0:
  - digit0 decrements. On 0 it goes to 9 and borrows from digit1, and so on.
  - A borrow out of digit3 wraps the count to 9999 and sets wrap.
- Non-step cycles: digits hold and wrap is 0.
- Digits never hold values outside 0–9. Bits [6:4] of every digit output are constant 0.

## Timing
- All outputs except step are registered. step is combinational from the prescaler, en, clr and load.
- Latency:
  - The count changes at the edge that ends a step cycle.
  - The new value is visible 1 cycle after step is high.
  - wrap is high in the same cycle the wrapped value first appears, for exactly 1 cycle.
- Step interval with en held high: one step every TICK_DIV cycles. The first step after reset, clr or load comes TICK_DIV cycles later.
- Lowering en mid-interval pauses the prescaler. Raising it again resumes with no lost or extra cycle.
- Changing up between steps is allowed. Only the value of up in the step cycle matters.
- load or clr in a step cycle: the step is discarded, no wrap is produced, and step reads 0.
- Reset mid-count: outputs read 0 in the cycle after the reset edge. Counting resumes TICK_DIV enabled cycles after rst_n returns high.

## Test plan
- Reset/free-run, TICK_DIV=4, en=1, up=1, from reset:
  - step is high every 4th cycle.
  - After 40 cycles the digits read 0,1,0,0 (digit0..digit3), i.e. the count is 10.
- Up wrap: load 0x9998, then run up.
  - After two steps the digits read 0,0,0,0.
  - wrap is high for 1 cycle, coincident with the first 0000.
- Down wrap/borrow: load 0x0000, run with up=0.
  - After one step the count is 9999 and wrap pulses.
  - Load 0x1000 and take one down step: the count is 0999.
- Illegal load: load_val=0xA5F3 → digits 3,0,5,0 (thousands = 0, hundreds = 5, tens = 0, units = 3).
- Pause/priority, TICK_DIV=4:
  - Drop en for 10 cycles mid-interval: the next step is delayed by exactly 10 cycles.
  - Assert clr together with load in a step cycle: count 0000, no step, no wrap.
- Reset mid-operation: pull rst_n low for 1 cycle while the count is 0457.
  - Next cycle the digits read 0,0,0,0 and wrap reads 0.
  - The first step comes 4 enabled cycles after rst_n rises.

Source files
------------

// File: rtl/bcd_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_counter_if                                                        |
// | Control inputs and digit/status outputs of the four-digit BCD counter.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface bcd_counter_if;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [6:0]  digit0;
    logic [6:0]  digit1;
    logic [6:0]  digit2;
    logic [6:0]  digit3;
    logic        step;
    logic        wrap;

    modport master (
        output en, up, clr, load, load_val,
        input  digit0, digit1, digit2, digit3, step, wrap
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output digit0, digit1, digit2, digit3, step, wrap
    );
endinterface
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_counter                                                           |
// | Four-digit BCD up/down counter stepped by an en-gated prescaler.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module bcd_counter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_counter_if.slave  bus
);
    localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [15:0]        r_dig;
    logic               r_wrap;

    logic        w_step;
    logic [3:0]  w_lim;
    logic [3:0]  w_cin;
    logic [15:0] w_nxt;
    logic [15:0] w_ld;
    logic        w_cout;

    assign w_step = bus.en & (r_pre == c_PRE_MAX) & ~bus.clr & ~bus.load;

    // A digit rolls over when it sits at its limit and every lower digit does too.
    always_comb begin
        w_cin[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            w_cin[i] = w_cin[i-1] & w_lim[i-1];
        end
    end
    assign w_cout = w_cin[3] & w_lim[3];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_src;

        assign w_cur     = r_dig[4*gi +: 4];
        assign w_src     = bus.load_val[4*gi +: 4];
        assign w_lim[gi] = bus.up ? (w_cur == 4'd9) : (w_cur == 4'd0);
        assign w_ld[4*gi +: 4] = (w_src > 4'd9) ? 4'd0 : w_src;

        always_comb begin
            w_nxt[4*gi +: 4] = w_cur;
            if (w_cin[gi]) begin
                if (bus.up) begin
                    w_nxt[4*gi +: 4] = w_lim[gi] ? 4'd0 : w_cur + 4'd1;
                end else begin
                    w_nxt[4*gi +: 4] = w_lim[gi] ? 4'd9 : w_cur - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dig  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else if (bus.clr) begin
            r_dig  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_dig  <= w_ld;
            r_pre  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step & w_cout;
            if (w_step) begin
                r_dig <= w_nxt;
            end
            if (bus.en) begin
                r_pre <= (r_pre == c_PRE_MAX) ? '0 : r_pre + 1'b1;
            end
        end
    end

    assign bus.digit0 = {3'b000, r_dig[3:0]};
    assign bus.digit1 = {3'b000, r_dig[7:4]};
    assign bus.digit2 = {3'b000, r_dig[11:8]};
    assign bus.digit3 = {3'b000, r_dig[15:12]};
    assign bus.step   = w_step;
    assign bus.wrap   = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_bcd_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bcd_counter                                                        |
// | Checks bcd_counter against an integer-count reference model.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_bcd_counter;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bcd_counter_if bus ();

    bcd_counter #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: the count as a plain integer 0..9999 plus a cycle counter.
    int m_cnt  = 0;
    int m_pre  = 0;
    bit m_wrap = 1'b0;
    bit e_step;
    bit s_step;

    function automatic int ld_decode(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int n = int'(v[4*i +: 4]);
            r = r * 10 + ((n > 9) ? 0 : n);
        end
        return r;
    endfunction

    function automatic int dut_cnt();
        return int'(bus.digit3) * 1000 + int'(bus.digit2) * 100 +
               int'(bus.digit1) * 10 + int'(bus.digit0);
    endfunction

    task automatic cycle();
        int old;
        @(negedge clk);
        s_step = bus.step;
        e_step = bus.en && (m_pre == TD - 1) && !bus.clr && !bus.load;
        @(posedge clk);
        if (!rst_n || bus.clr) begin
            m_cnt = 0; m_pre = 0; m_wrap = 0;
        end else if (bus.load) begin
            m_cnt = ld_decode(bus.load_val); m_pre = 0; m_wrap = 0;
        end else if (e_step) begin
            old    = m_cnt;
            m_cnt  = bus.up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
            m_wrap = bus.up ? (old == 9999) : (old == 0);
            m_pre  = 0;
        end else begin
            if (bus.en) m_pre = m_pre + 1;
            m_wrap = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; bus.en = 0; bus.up = 1; bus.clr = 0; bus.load = 0; bus.load_val = '0;
        cycle(); cycle();
        total++;
        if (dut_cnt() !== 0 || bus.wrap !== 1'b0) $display("FAIL reset: count=%0d wrap=%b, required 0/0", dut_cnt(), bus.wrap);
        else passed++;
        total++;
        if ({bus.digit3[6:4], bus.digit2[6:4], bus.digit1[6:4], bus.digit0[6:4]} !== 12'h0)
            $display("FAIL reset_upper_bits: nonzero upper digit bits");
        else passed++;
        rst_n = 1;
    endtask

    task automatic test_free_run();
        bus.en = 1; bus.up = 1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            total++;
            if (s_step !== e_step) $display("FAIL free_run_step cyc %0d: step=%b, required %b", i, s_step, e_step);
            else passed++;
        end
        total++;
        if (dut_cnt() !== 10 || m_cnt != 10) $display("FAIL free_run_count: count=%0d, required 10", dut_cnt());
        else passed++;
    endtask

    task automatic run_compare(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            total++;
            if (s_step !== e_step || dut_cnt() !== m_cnt || bus.wrap !== m_wrap)
                $display("FAIL %s cyc %0d: step=%b count=%0d wrap=%b, required step=%b count=%0d wrap=%b",
                         name, i, s_step, dut_cnt(), bus.wrap, e_step, m_cnt, m_wrap);
            else passed++;
        end
    endtask

    task automatic test_up_wrap();
        int wraps = 0;
        bus.load = 1; bus.load_val = 16'h9998; bus.en = 1; bus.up = 1;
        cycle();
        bus.load = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            cycle();
            if (bus.wrap === 1'b1) wraps++;
            total++;
            if (dut_cnt() !== m_cnt || bus.wrap !== m_wrap)
                $display("FAIL up_wrap cyc %0d: count=%0d wrap=%b, required %0d/%b", i, dut_cnt(), bus.wrap, m_cnt, m_wrap);
            else passed++;
        end
        total++;
        if (dut_cnt() !== 0 || wraps !== 1) $display("FAIL up_wrap_final: count=%0d wraps=%0d, required 0/1", dut_cnt(), wraps);
        else passed++;
    endtask

    task automatic test_down_wrap();
        bus.load = 1; bus.load_val = 16'h0000; bus.up = 0;
        cycle();
        bus.load = 0;
        run_compare("down_wrap", TD);
        total++;
        if (dut_cnt() !== 9999 || bus.wrap !== 1'b1) $display("FAIL down_wrap_final: count=%0d wrap=%b, required 9999/1", dut_cnt(), bus.wrap);
        else passed++;
        bus.load = 1; bus.load_val = 16'h1000;
        cycle();
        bus.load = 0;
        run_compare("down_borrow", TD);
        total++;
        if (dut_cnt() !== 999) $display("FAIL down_borrow_final: count=%0d, required 999", dut_cnt());
        else passed++;
    endtask

    task automatic test_illegal_load();
        bus.en = 0; bus.load = 1; bus.load_val = 16'hA5F3;
        cycle();
        bus.load = 0;
        total++;
        if (bus.digit3 !== 7'd0 || bus.digit2 !== 7'd5 || bus.digit1 !== 7'd0 || bus.digit0 !== 7'd3)
            $display("FAIL illegal_load: digits=%0d,%0d,%0d,%0d, required 0,5,0,3",
                     bus.digit3, bus.digit2, bus.digit1, bus.digit0);
        else passed++;
    endtask

    task automatic test_pause();
        int n = 0;
        bit seen = 0;
        bus.load = 1; bus.load_val = 16'h0000; bus.en = 1; bus.up = 1;
        cycle();
        bus.load = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.en = (n >= 2 && n < 12) ? 1'b0 : 1'b1;
            cycle();
            n++;
            total++;
            if (s_step !== e_step) $display("FAIL pause_step cyc %0d: step=%b, required %b", n, s_step, e_step);
            else passed++;
            if (s_step) seen = 1;
        end
        total++;
        if (!seen || n !== TD + 10) $display("FAIL pause_delay: step after %0d cycles, required %0d", n, TD + 10);
        else passed++;
    endtask

    task automatic test_priority();
        bus.load = 1; bus.load_val = 16'h9999; bus.en = 1; bus.up = 1;
        cycle();
        bus.load = 0;
        run_compare("prio_pre", TD - 1);
        bus.clr = 1; bus.load = 1; bus.load_val = 16'h1234;
        cycle();
        bus.clr = 0; bus.load = 0;
        total++;
        if (s_step !== 1'b0 || dut_cnt() !== 0 || bus.wrap !== 1'b0)
            $display("FAIL priority: step=%b count=%0d wrap=%b, required 0/0/0", s_step, dut_cnt(), bus.wrap);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 0;
        bus.load = 1; bus.load_val = 16'h0457; bus.en = 1; bus.up = 1;
        cycle();
        bus.load = 0;
        run_compare("rst_mid_pre", 2);
        rst_n = 0;
        cycle();
        rst_n = 1;
        total++;
        if (dut_cnt() !== 0 || bus.wrap !== 1'b0) $display("FAIL reset_mid: count=%0d wrap=%b, required 0/0", dut_cnt(), bus.wrap);
        else passed++;
        for (int i = 0; i < 3 * TD && !seen; i++) begin
            cycle();
            n++;
            if (s_step) seen = 1;
        end
        total++;
        if (!seen || n !== TD) $display("FAIL reset_mid_first_step: step in cycle %0d, required %0d", n, TD);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(99) >= 2);
            bus.en       = ($urandom_range(3) != 0);
            bus.up       = $urandom_range(1);
            bus.clr      = ($urandom_range(99) < 3);
            bus.load     = ($urandom_range(99) < 6);
            bus.load_val = (i % 3 == 0) ? 16'(ld_decode(16'($urandom)) == 0 ? 16'h9999 : 16'h0001)
                                        : 16'($urandom);
            cycle();
            total++;
            if (s_step !== e_step || dut_cnt() !== m_cnt || bus.wrap !== m_wrap)
                $display("FAIL random cyc %0d: step=%b count=%0d wrap=%b, required step=%b count=%0d wrap=%b",
                         i, s_step, dut_cnt(), bus.wrap, e_step, m_cnt, m_wrap);
            else passed++;
        end
        rst_n = 1; bus.clr = 0; bus.load = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_up_wrap();
        test_down_wrap();
        test_illegal_load();
        test_pause();
        test_priority();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
